clint: RTL and testbench

- Core-local interruptor for a single hart. Generates the machine timer and software interrupt-pending levels that drive the CSR block's xTIP/xSIP inputs.
- Holds a 64-bit free-running mtime counter, a 64-bit mtimecmp compare register and an msip register.
- All three are reachable through a simple memory-mapped request/acknowledge slave port, decoded by the core's load/store path.

---
 rtl/clint_pkg.sv | 31 +++
 rtl/clint_timer.sv | 102 ++++++++++
 rtl/clint.sv | 112 +++++++++++
 tb/tb_clint.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: shared definitions for the core-local interruptor.
//   - Word offsets of the memory-mapped CLINT registers.
//   - Bus FSM state type.
//   - Byte-strobe merge helper used by every writable register.
// The optional mtime prescaler is selected with the CLINT_PRESCALER_EN macro
// (see clint_timer.sv); nothing in this package depends on it.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } clint_state_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] clint_merge(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// clint_timer: 64-bit mtime counter, 64-bit mtimecmp register and the
// registered timer-match level.
//
// Configuration macro: CLINT_PRESCALER_EN
//   defined   - mtime advances once every PRESCALE clocks
//   undefined - mtime advances every clock, no prescale counter
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mtime_lo_we_i/hi      write strobe for mtime[31:0] / mtime[63:32]
//   mtimecmp_lo_we_i/hi   write strobe for mtimecmp[31:0] / mtimecmp[63:32]
//   wstrb_i, wdata_i      byte enables and data shared by all writes
//   mtime_o, mtimecmp_o   current register values for the read mux
//   match_o               registered (mtime >= mtimecmp), unsigned
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int unsigned PRESCALE     = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtime_lo_we_i,
    input  logic        mtime_hi_we_i,
    input  logic        mtimecmp_lo_we_i,
    input  logic        mtimecmp_hi_we_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] mtime_o,
    output logic [63:0] mtimecmp_o,
    output logic        match_o
);

    if (PRESCALE < 1) begin : g_prescale_chk
        $error("clint_timer: PRESCALE must be at least 1");
    end

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        match_q;
    logic        tick;

`ifdef CLINT_PRESCALER_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q, ps_d;

    // Free-running divider; bus writes to mtime do not disturb it.
    always_comb begin
        tick = (ps_q == PS_W'(PRESCALE - 1));
        ps_d = tick ? '0 : ps_q + PS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ps_q <= '0;
        else        ps_q <= ps_d;
    end
`else
    assign tick = 1'b1;
`endif

    // A bus write to either half wins over the tick: the other half holds and
    // no carry is applied, so a suppressed tick is simply lost.
    always_comb begin
        mtime_d = mtime_q;
        if (mtime_lo_we_i) begin
            mtime_d[31:0] = clint_merge(mtime_q[31:0], wdata_i, wstrb_i);
        end else if (mtime_hi_we_i) begin
            mtime_d[63:32] = clint_merge(mtime_q[63:32], wdata_i, wstrb_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (mtimecmp_lo_we_i) begin
            mtimecmp_d[31:0] = clint_merge(mtimecmp_q[31:0], wdata_i, wstrb_i);
        end
        if (mtimecmp_hi_we_i) begin
            mtimecmp_d[63:32] = clint_merge(mtimecmp_q[63:32], wdata_i, wstrb_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            match_q    <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            // Compare uses the pre-edge values, so updates show one cycle late.
            match_q    <= (mtime_q >= mtimecmp_q);
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = mtimecmp_q;
    assign match_o    = match_q;

endmodule

// File: rtl/clint.sv
// clint: core-local interruptor for a single hart.
//   Memory-mapped msip / mtimecmp / mtime behind a req/ack slave port, driving
//   the machine timer (xTIP) and software (xSIP) interrupt-pending levels.
//
// Configuration macro: CLINT_PRESCALER_EN (mtime prescaler, see clint_timer).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req, we      bus request (held until ack) and write/read select
//   addr         byte offset within the CLINT window
//   wdata, wstrb write data and byte enables
//   rdata        read data, valid while ack, held otherwise
//   ack          one-cycle response pulse, one cycle after req is taken
//   xTIP, xSIP   timer / software interrupt pending
module clint
    import clint_pkg::*;
#(
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int unsigned PRESCALE     = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        xTIP,
    output logic        xSIP
);

    clint_state_t state_q, state_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         msip_q, msip_d;
    logic         xsip_q;

    logic         accept;
    logic         wr;
    logic [31:0]  rmux;
    logic [63:0]  mtime;
    logic [63:0]  mtimecmp;

    // The access is taken (write performed, read data captured) on the edge
    // that leaves IDLE; RESP only presents ack.
    assign accept = (state_q == IDLE) && req;
    assign wr     = accept && we;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        unique case (addr)
            CLINT_MSIP_OFF:        rmux = {31'b0, msip_q};
            CLINT_MTIMECMP_LO_OFF: rmux = mtimecmp[31:0];
            CLINT_MTIMECMP_HI_OFF: rmux = mtimecmp[63:32];
            CLINT_MTIME_LO_OFF:    rmux = mtime[31:0];
            CLINT_MTIME_HI_OFF:    rmux = mtime[63:32];
            default:               rmux = 32'b0;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        msip_d  = msip_q;
        if (accept) rdata_d = rmux;
        if (wr && (addr == CLINT_MSIP_OFF) && wstrb[0]) msip_d = wdata[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
            msip_q  <= 1'b0;
            xsip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            msip_q  <= msip_d;
            xsip_q  <= msip_q;
        end
    end

    clint_timer #(
        .MTIMECMP_RST (MTIMECMP_RST),
        .PRESCALE     (PRESCALE)
    ) u_timer (
        .clk              (clk),
        .rst_n            (rst_n),
        .mtime_lo_we_i    (wr && (addr == CLINT_MTIME_LO_OFF)),
        .mtime_hi_we_i    (wr && (addr == CLINT_MTIME_HI_OFF)),
        .mtimecmp_lo_we_i (wr && (addr == CLINT_MTIMECMP_LO_OFF)),
        .mtimecmp_hi_we_i (wr && (addr == CLINT_MTIMECMP_HI_OFF)),
        .wstrb_i          (wstrb),
        .wdata_i          (wdata),
        .mtime_o          (mtime),
        .mtimecmp_o       (mtimecmp),
        .match_o          (xTIP)
    );

    assign ack   = (state_q == RESP);
    assign rdata = rdata_q;
    assign xSIP  = xsip_q;

endmodule

// File: tb/tb_clint.sv
// tb_clint: directed self-checking bench for clint.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_clint;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [15:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        xTIP;
    logic        xSIP;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    clint #(
        .PRESCALE (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .wstrb (wstrb),
        .rdata (rdata),
        .ack   (ack),
        .xTIP  (xTIP),
        .xSIP  (xSIP)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One bus access starting at a falling edge; ack must appear after exactly
    // one rising edge and last exactly one cycle.
    task automatic bus_xfer(input logic [15:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        wstrb = s;
        @(negedge clk);
        check_eq("ack_latency", ack, 1'b1);
        rd  = rdata;
        req = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        check_eq("ack_pulse", ack, 1'b0);
    endtask

    task automatic wr32(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] unused_rd;
        bus_xfer(a, 1'b1, d, s, unused_rd);
    endtask

    task automatic rd32(input logic [15:0] a, output logic [31:0] v);
        bus_xfer(a, 1'b0, 32'h0, 4'h0, v);
    endtask

    initial begin
        logic [31:0] v;

        // Reset state
        @(negedge clk);
        check_eq("rst_ack", ack, 1'b0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_xtip", xTIP, 1'b0);
        check_eq("rst_xsip", xSIP, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef CLINT_PRESCALER_EN
        // PRESCALE = 4: 100 clocks give 25 ticks; the read samples the
        // pre-edge value on the 101st edge.
        repeat (100) @(negedge clk);
        rd32(16'hBFF8, v);
        check_eq("ps_mtime_lo", v, 32'd25);
        rd32(16'h4004, v);
        check_eq("ps_mtimecmp_hi_rst", v, 32'hFFFF_FFFF);
`else
        // Idle 10 cycles: mtime = 10 when the read is taken
        repeat (10) @(negedge clk);
        check_eq("idle_xtip", xTIP, 1'b0);
        check_eq("idle_xsip", xSIP, 1'b0);
        rd32(16'hBFF8, v);
        check_eq("idle_mtime_lo", v, 32'd10);
        rd32(16'h4000, v);
        check_eq("mtimecmp_lo_rst", v, 32'hFFFF_FFFF);

        // mtime=5, cmp={0,0x20}; three writes leave mtime = 10
        wr32(16'hBFF8, 32'd5, 4'hF);
        wr32(16'h4004, 32'h0, 4'hF);
        wr32(16'h4000, 32'h20, 4'hF);
        repeat (22) @(negedge clk);      // mtime just reached 0x20
        check_eq("tip_before", xTIP, 1'b0);
        @(negedge clk);
        check_eq("tip_rise", xTIP, 1'b1);
        wr32(16'h4000, 32'hFFFF_FFFF, 4'hF);
        check_eq("tip_fall", xTIP, 1'b0);
        rd32(16'h4000, v);
        check_eq("mtimecmp_lo_rd", v, 32'hFFFF_FFFF);
        rd32(16'h4004, v);
        check_eq("mtimecmp_hi_rd", v, 32'h0);

        // Wrap: cmp = 0, mtime set to all-ones, then wraps to 0
        wr32(16'h4000, 32'h0, 4'hF);
        check_eq("wrap_tip0", xTIP, 1'b1);
        wr32(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        check_eq("wrap_tip1", xTIP, 1'b1);
        wr32(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        check_eq("wrap_tip2", xTIP, 1'b1);
        rd32(16'hBFF8, v);
        check_eq("wrap_mtime_lo", v, 32'h0);
        check_eq("wrap_tip3", xTIP, 1'b1);
        rd32(16'hBFFC, v);
        check_eq("wrap_mtime_hi", v, 32'h0);

        // Byte strobe: mtime is 0x1234 when the strobed write lands
        wr32(16'hBFF8, 32'h1233, 4'hF);
        wr32(16'hBFF8, 32'h0000_AB00, 4'b0010);
        rd32(16'hBFF8, v);
        check_eq("strb_mtime_lo", v, 32'h0000_AB35);
        rd32(16'hBFFC, v);
        check_eq("strb_mtime_hi", v, 32'h0);
`endif

        // msip / xSIP
        wr32(16'h0000, 32'h1, 4'hF);
        check_eq("xsip_set", xSIP, 1'b1);
        rd32(16'h0000, v);
        check_eq("msip_rd1", v, 32'h1);
        wr32(16'h0000, 32'h0, 4'hF);
        check_eq("xsip_clr", xSIP, 1'b0);
        wr32(16'h0000, 32'h1, 4'h0);
        check_eq("xsip_nostrb", xSIP, 1'b0);
        rd32(16'h0000, v);
        check_eq("msip_nostrb", v, 32'h0);
        wr32(16'h0000, 32'hFFFF_FFFF, 4'hF);
        rd32(16'h0000, v);
        check_eq("msip_upper0", v, 32'h1);
        wr32(16'h0000, 32'h0, 4'hF);

        // Unmapped offset
        wr32(16'h1000, 32'hDEAD_BEEF, 4'hF);
        rd32(16'h1000, v);
        check_eq("unmapped_rd", v, 32'h0);
        rd32(16'h0000, v);
        check_eq("unmapped_msip", v, 32'h0);
        check_eq("unmapped_xsip", xSIP, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
